// File: rtl/sync_debounce.sv
// Purpose : glitch filter + edge detector behind a sync synchronizer; forwards a level
//           change only after it has held for HOLD_CYCLES consecutive enabled samples.
// Latency : a new level held from edge k shows on level_o/rise_o/fall_o after edge k+HOLD_CYCLES-1.
// Backpr. : none; the block samples serial_i every cycle and never stalls.
//
// Ports:
//   clk_i      single clock
//   rst_i      asynchronous, active-high reset
//   serial_i   already-synchronized input level
//   en_i       filter enable; low discards any pending change and holds level_o
//   level_o    debounced level (state flop)
//   rise_o     one-cycle pulse on a filtered 0->1 change (registered)
//   fall_o     one-cycle pulse on a filtered 1->0 change (registered)
//   evt_clr_i  synchronous clear of the edge counter (wins over an increment)
//   evt_cnt_o  saturating count of filtered edges
//
// Build option: define SYNC_DEBOUNCE_EVT_CNT_EN to build the edge counter. Without it,
// evt_cnt_o is tied to zero and evt_clr_i is ignored; filtering is identical.

module sync_debounce #(
    parameter int   HOLD_CYCLES   = 16,
    parameter logic RESET_VALUE   = 1'b0,
    parameter int   EVT_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     serial_i,
    input  logic                     en_i,
    output logic                     level_o,
    output logic                     rise_o,
    output logic                     fall_o,
    input  logic                     evt_clr_i,
    output logic [EVT_CNT_WIDTH-1:0] evt_cnt_o
);

    localparam int CNT_WIDTH = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("sync_debounce: HOLD_CYCLES must be >= 1");
    end

    // Bit 0 is the level currently shown on level_o, bit 1 marks a pending
    // candidate change, so level_o comes straight off a flop.
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        STABLE_HI = 2'b01,
        CHECK_HI  = 2'b10,
        CHECK_LO  = 2'b11
    } state_t;

    localparam state_t RESET_STATE = RESET_VALUE ? STABLE_HI : STABLE_LO;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   hold_cnt_q;
    logic [CNT_WIDTH-1:0]   hold_cnt_d;
    logic                   level;
    logic                   mismatch;
    logic                   flip;
    logic                   rise_d;
    logic                   fall_d;

    assign level    = state_q[0];
    assign mismatch = (serial_i != level);
    assign level_o  = level;

    // ------------------------------------------------------------------
    // State register (FSM state and hold counter)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RESET_STATE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        flip       = 1'b0;

        if (!en_i) begin
            // Drop any pending candidate; the shown level is kept.
            state_d    = level ? STABLE_HI : STABLE_LO;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                STABLE_LO, STABLE_HI: begin
                    if (mismatch) begin
                        if (HOLD_CYCLES == 1) begin
                            // A single sample is enough: no CHECK phase.
                            flip    = 1'b1;
                            state_d = level ? STABLE_LO : STABLE_HI;
                        end else begin
                            // This edge is the first of the HOLD_CYCLES samples.
                            state_d    = level ? CHECK_LO : CHECK_HI;
                            hold_cnt_d = CNT_ONE;
                        end
                    end
                end
                CHECK_HI, CHECK_LO: begin
                    if (!mismatch) begin
                        // Glitch: input fell back before the hold time expired.
                        state_d    = level ? STABLE_HI : STABLE_LO;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        flip       = 1'b1;
                        state_d    = level ? STABLE_LO : STABLE_HI;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d    = RESET_STATE;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: pulse direction follows the level being left behind
    // ------------------------------------------------------------------
    always_comb begin
        rise_d = flip & ~level;
        fall_d = flip &  level;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            rise_o <= rise_d;
            fall_o <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional saturating edge counter
    // ------------------------------------------------------------------
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    logic [EVT_CNT_WIDTH-1:0] evt_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_cnt_q <= '0;
        end else if (evt_clr_i) begin
            evt_cnt_q <= '0;
        end else if (flip && (evt_cnt_q != '1)) begin
            evt_cnt_q <= evt_cnt_q + EVT_CNT_WIDTH'(1);
        end
    end

    assign evt_cnt_o = evt_cnt_q;
`else
    logic unused_evt;

    assign evt_cnt_o  = '0;
    assign unused_evt = evt_clr_i ^ flip;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Instance a: HOLD=4, reset 0, 2-bit counter (directed table + random)
    // Instance b: HOLD=4, reset 1, 8-bit counter
    // Instance c: HOLD=1, reset 0, 8-bit counter
    localparam int HOLD_A = 4;
    localparam int HOLD_B = 4;
    localparam int HOLD_C = 1;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic       evt_clr_i;
    logic       ser_a, ser_b, ser_c;
    logic       lvl_a, lvl_b, lvl_c;
    logic       rise_a, rise_b, rise_c;
    logic       fall_a, fall_b, fall_c;
    logic [1:0] cnt_a;
    logic [7:0] cnt_b, cnt_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    sync_debounce #(.HOLD_CYCLES(HOLD_A), .RESET_VALUE(1'b0), .EVT_CNT_WIDTH(2)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .serial_i(ser_a), .en_i(en_i),
        .level_o(lvl_a), .rise_o(rise_a), .fall_o(fall_a),
        .evt_clr_i(evt_clr_i), .evt_cnt_o(cnt_a)
    );

    sync_debounce #(.HOLD_CYCLES(HOLD_B), .RESET_VALUE(1'b1), .EVT_CNT_WIDTH(8)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .serial_i(ser_b), .en_i(en_i),
        .level_o(lvl_b), .rise_o(rise_b), .fall_o(fall_b),
        .evt_clr_i(evt_clr_i), .evt_cnt_o(cnt_b)
    );

    sync_debounce #(.HOLD_CYCLES(HOLD_C), .RESET_VALUE(1'b0), .EVT_CNT_WIDTH(8)) u_c (
        .clk_i(clk_i), .rst_i(rst_i), .serial_i(ser_c), .en_i(en_i),
        .level_o(lvl_c), .rise_o(rise_c), .fall_o(fall_c),
        .evt_clr_i(evt_clr_i), .evt_cnt_o(cnt_c)
    );

    // Reference model: a change is accepted once the input has disagreed with
    // the shown level for HOLD consecutive enabled samples.
    typedef struct {
        bit level;
        int run;
        bit rise;
        bit fall;
        int cnt;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t mdl_reset(bit rv);
        mdl_t m;
        m.level = rv;
        m.run   = 0;
        m.rise  = 0;
        m.fall  = 0;
        m.cnt   = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit ser, bit en, bit clr, int hold, int cmax);
        mdl_t n = m;
        n.rise = 0;
        n.fall = 0;
        n.run  = (en && (ser != m.level)) ? m.run + 1 : 0;
        if (n.run >= hold) begin
            n.level = ser;
            n.run   = 0;
            n.rise  = ser;
            n.fall  = !ser;
            if (n.cnt < cmax) n.cnt = n.cnt + 1;
        end
        if (clr) n.cnt = 0;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input string tag, input mdl_t m, input logic l, input logic r,
                            input logic f, input logic [31:0] c);
        check({tag, ".level"}, 32'(l), 32'(m.level));
        check({tag, ".rise"},  32'(r), 32'(m.rise));
        check({tag, ".fall"},  32'(f), 32'(m.fall));
        check({tag, ".cnt"},   c, CNT_EN ? 32'(m.cnt) : 32'd0);
        check({tag, ".rise_and_fall"}, 32'(r & f), 32'd0);
    endtask

    task automatic compare_all();
        cmp_inst("a", ma, lvl_a, rise_a, fall_a, 32'(cnt_a));
        cmp_inst("b", mb, lvl_b, rise_b, fall_b, 32'(cnt_b));
        cmp_inst("c", mc, lvl_c, rise_c, fall_c, 32'(cnt_c));
    endtask

    // One clock: advance models with the inputs present at the edge, then
    // compare shortly after the edge.
    task automatic cyc();
        @(posedge clk_i);
        if (rst_i) begin
            ma = mdl_reset(1'b0);
            mb = mdl_reset(1'b1);
            mc = mdl_reset(1'b0);
        end else begin
            ma = mdl_step(ma, ser_a, en_i, evt_clr_i, HOLD_A, 3);
            mb = mdl_step(mb, ser_b, en_i, evt_clr_i, HOLD_B, 255);
            mc = mdl_step(mc, ser_c, en_i, evt_clr_i, HOLD_C, 255);
        end
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must drop at once.
    task automatic pulse_rst();
        #1 rst_i = 1'b1;
        #1;
        ma = mdl_reset(1'b0);
        mb = mdl_reset(1'b1);
        mc = mdl_reset(1'b0);
        compare_all();
        cyc();
        rst_i = 1'b0;
    endtask

    typedef struct {
        bit ser;
        bit en;
        bit clr;
        bit lvl;
        bit rise;
        bit fall;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add_n(input int n, input bit ser, input bit en, input bit clr,
                         input bit lvl, input bit rise, input bit fall, input int cnt);
        vec_t v;
        v.ser = ser; v.en = en; v.clr = clr;
        v.lvl = lvl; v.rise = rise; v.fall = fall; v.cnt = cnt;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        // Directed vectors for instance a; row i is edge i after reset release.
        //     n  ser en clr  lvl rise fall cnt
        add_n(9,  0,  1, 0,   0,  0,   0,   0); // idle
        add_n(3,  1,  1, 0,   0,  0,   0,   0); // edges 10..12 hold
        add_n(1,  1,  1, 0,   1,  1,   0,   1); // edge 13 rise
        add_n(3,  1,  1, 0,   1,  0,   0,   1);
        add_n(3,  0,  1, 0,   1,  0,   0,   1); // 3-cycle glitch low
        add_n(2,  1,  1, 0,   1,  0,   0,   1); // rejected
        add_n(3,  0,  1, 0,   1,  0,   0,   1); // 4-cycle low
        add_n(1,  0,  1, 0,   0,  0,   1,   2); // fall
        add_n(1,  0,  1, 0,   0,  0,   0,   2);
        add_n(2,  1,  1, 0,   0,  0,   0,   2); // count reaches 2
        add_n(5,  1,  0, 0,   0,  0,   0,   2); // en low 5 cycles
        add_n(3,  1,  1, 0,   0,  0,   0,   2); // restarted count
        add_n(1,  1,  1, 0,   1,  1,   0,   3); // 4 edges after re-enable
        add_n(1,  1,  1, 0,   1,  0,   0,   3);
        add_n(3,  0,  1, 0,   1,  0,   0,   3);
        add_n(1,  0,  1, 0,   0,  0,   1,   3); // 4th edge
        add_n(1,  0,  1, 0,   0,  0,   0,   3);
        add_n(3,  1,  1, 0,   0,  0,   0,   3);
        add_n(1,  1,  1, 0,   1,  1,   0,   3); // 5th edge, saturated
        add_n(3,  0,  1, 0,   1,  0,   0,   3);
        add_n(1,  0,  1, 1,   0,  0,   1,   0); // clear wins over edge
        add_n(1,  0,  1, 0,   0,  0,   0,   0);

        rst_i     = 1'b1;
        en_i      = 1'b1;
        evt_clr_i = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b1;
        ser_c     = 1'b0;
        ma = mdl_reset(1'b0);
        mb = mdl_reset(1'b1);
        mc = mdl_reset(1'b0);

        // Reset values while reset is held
        #2;
        check("rst.b.level", 32'(lvl_b), 32'd1);
        check("rst.b.rise",  32'(rise_b), 32'd0);
        check("rst.b.fall",  32'(fall_b), 32'd0);
        check("rst.a.level", 32'(lvl_a), 32'd0);
        check("rst.a.cnt",   32'(cnt_a), 32'd0);
        repeat (3) cyc();
        rst_i = 1'b0;

        // Directed table on instance a; b holds 1, c sees random input
        for (int i = 0; i < tbl.size(); i++) begin
            ser_a     = tbl[i].ser;
            en_i      = tbl[i].en;
            evt_clr_i = tbl[i].clr;
            ser_c     = 1'($urandom_range(1));
            cyc();
            check($sformatf("tbl[%0d].level", i + 1), 32'(lvl_a), 32'(tbl[i].lvl));
            check($sformatf("tbl[%0d].rise", i + 1),  32'(rise_a), 32'(tbl[i].rise));
            check($sformatf("tbl[%0d].fall", i + 1),  32'(fall_a), 32'(tbl[i].fall));
            check($sformatf("tbl[%0d].cnt", i + 1),   32'(cnt_a),
                  CNT_EN ? 32'(tbl[i].cnt) : 32'd0);
            check($sformatf("tbl[%0d].b_level", i + 1), 32'(lvl_b), 32'd1);
        end
        evt_clr_i = 1'b0;
        en_i      = 1'b1;

        // Reset in the middle of a pending rise on a
        ser_a = 1'b1;
        cyc();
        cyc();
        pulse_rst();
        check("midrst.a.level", 32'(lvl_a), 32'd0);
        check("midrst.a.rise",  32'(rise_a), 32'd0);
        ser_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("midrst.a.no_pulse", 32'(rise_a | fall_a), 32'd0);
        end

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) ser_a = !ser_a;
            if ($urandom_range(5) == 0) ser_b = !ser_b;
            if ($urandom_range(2) == 0) ser_c = !ser_c;
            en_i      = ($urandom_range(19) != 0);
            evt_clr_i = ($urandom_range(59) == 0);
            if ($urandom_range(499) == 0) pulse_rst();
            else cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
